// File: rtl/uart_reg_bridge_pkg.sv
// Shared constants, state encodings and helpers for the UART register bridge.
package uart_reg_bridge_pkg;

  localparam logic [7:0] SYNC_RX   = 8'hA5;
  localparam logic [7:0] SYNC_TX   = 8'h5A;
  localparam logic [7:0] CMD_RD    = 8'h01;
  localparam logic [7:0] CMD_WR    = 8'h02;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCHK = 8'h01;
  localparam logic [7:0] ST_BADCMD = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_BUS  = 3'd5,
    S_RSP  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_PULSE = 2'd2,
    TX_GAP   = 2'd3
  } tx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_reg_bridge_txseq.sv
// Sends the 4-byte response 5A, STATUS, DATA, RCHK over the txrdy/tx_vld
// handshake; pulses done once the last byte has left the UART.
module uart_reg_bridge_txseq
  import uart_reg_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] status,
  input  logic [7:0] data,
  input  logic       txrdy,
  output logic       tx_vld,
  output logic [7:0] tx_data,
  output logic       done
);

  tx_state_t  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] status_q, status_d;
  logic [7:0] data_q, data_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_vld_q, tx_vld_d;
  logic [7:0] cur_byte;

  always_comb begin
    case (idx_q)
      3'd0:    cur_byte = SYNC_TX;
      3'd1:    cur_byte = status_q;
      3'd2:    cur_byte = data_q;
      default: cur_byte = SYNC_TX ^ status_q ^ data_q;
    endcase
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no branch can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    status_d  = status_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    done      = 1'b0;
    case (state_q)
      TX_IDLE: if (start) begin
        status_d = status;
        data_d   = data;
        idx_d    = 3'd0;
        state_d  = TX_WAIT;
      end
      TX_WAIT: if (txrdy) begin
        if (idx_q == 3'd4) begin
          done    = 1'b1;
          state_d = TX_IDLE;
        end else begin
          tx_vld_d  = 1'b1;
          tx_data_d = cur_byte;
          idx_d     = idx_q + 3'd1;
          state_d   = TX_PULSE;
        end
      end
      // One dead cycle after the pulse lets the UART pull txrdy low.
      TX_PULSE: state_d = TX_GAP;
      TX_GAP:   state_d = TX_WAIT;
    endcase
  end

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      idx_q     <= 3'd0;
      status_q  <= 8'h00;
      data_q    <= 8'h00;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      status_q  <= status_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
    end
  end

  assign tx_vld  = tx_vld_q;
  assign tx_data = tx_data_q;

endmodule

// File: rtl/uart_reg_bridge.sv
// Frame parser and register-bus master between the UART and the register file.
// Optional inter-byte timeout: define UART_REG_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 57288
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic       txrdy,
  output logic       tx_vld,
  output logic [7:0] tx_data,
  output logic       reg_req,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic       busy,
  output logic [7:0] err_cnt
);

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] err_q, err_d;
  logic       req_q, req_d;
  logic       rsp_start, rsp_done;
  logic [7:0] rsp_status, rsp_data;
  logic [7:0] frame_chk;

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] idle_q, idle_d;
`endif

  assign frame_chk = cmd_q ^ addr_q ^ ((cmd_q == CMD_WR) ? wdata_q : 8'h00);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    req_d      = req_q;
    rsp_start  = 1'b0;
    rsp_status = ST_OK;
    rsp_data   = 8'h00;
    case (state_q)
      S_IDLE: if (rx_vld && rx_data == SYNC_RX) state_d = S_CMD;
      S_CMD: if (rx_vld) begin
        cmd_d   = rx_data;
        state_d = S_ADDR;
      end
      // Unknown commands take the short read-length path; rejected at CHK.
      S_ADDR: if (rx_vld) begin
        addr_d  = rx_data;
        state_d = (cmd_q == CMD_WR) ? S_DATA : S_CHK;
      end
      S_DATA: if (rx_vld) begin
        wdata_d = rx_data;
        state_d = S_CHK;
      end
      S_CHK: if (rx_vld) begin
        if (cmd_q != CMD_RD && cmd_q != CMD_WR) rsp_status = ST_BADCMD;
        else if (rx_data != frame_chk)          rsp_status = ST_BADCHK;
        if (rsp_status != ST_OK) begin
          err_d     = sat_inc8(err_q);
          rsp_start = 1'b1;
          state_d   = S_RSP;
        end else begin
          req_d   = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: if (reg_ack) begin
        req_d     = 1'b0;
        rsp_start = 1'b1;
        rsp_data  = (cmd_q == CMD_RD) ? reg_rdata : 8'h00;
        state_d   = S_RSP;
      end
      S_RSP: if (rsp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    idle_d = 16'd0;
    if (state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK} && !rx_vld) begin
      if (idle_q == TIMEOUT_LAST) begin
        state_d = S_IDLE;
        err_d   = sat_inc8(err_q);
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'h00;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      err_q   <= 8'h00;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= 16'd0;
    else        idle_q <= idle_d;
  end
`endif

  uart_reg_bridge_txseq u_txseq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (rsp_start),
    .status  (rsp_status),
    .data    (rsp_data),
    .txrdy   (txrdy),
    .tx_vld  (tx_vld),
    .tx_data (tx_data),
    .done    (rsp_done)
  );

  assign reg_req   = req_q;
  assign reg_we    = (cmd_q == CMD_WR);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomized self-checking bench for uart_reg_bridge with a frame-level
// reference model, a UART transmitter model and a register-bus responder.
module tb_uart_reg_bridge;
  import uart_reg_bridge_pkg::*;

  logic       clk, rst_n, rx_vld, txrdy, reg_ack;
  logic [7:0] rx_data, reg_rdata;
  logic       tx_vld, reg_req, reg_we, busy;
  logic [7:0] tx_data, reg_addr, reg_wdata, err_cnt;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         tx_len, bus_wait, rst_evt, bad_frames;
  logic [7:0] tx_q[$];
  acc_t       acc_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] junk_q[$];
  logic [7:0] inj_q[$];
  logic [7:0] mem[256];

  uart_reg_bridge #(.TIMEOUT_CYC(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data),
    .txrdy     (txrdy),
    .tx_vld    (tx_vld),
    .tx_data   (tx_data),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_vld  = 1'b1;
    rx_data = b;
    tick();
    rx_vld  = 1'b0;
    repeat (gap) tick();
  endtask

  // Every transmit request must find the UART idle; record the byte.
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (tx_vld) begin
        check("txrdy_at_vld", txrdy, 1);
        tx_q.push_back(tx_data);
      end
    end
  end

  // UART transmitter: busy for tx_len cycles after accepting a byte.
  initial begin : uart_model
    logic [7:0] b;
    int         evt;
    txrdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_vld && txrdy) begin
        b   = tx_data;
        evt = rst_evt;
        @(posedge clk);
        #1 txrdy = 1'b0;
        repeat (tx_len) @(posedge clk);
        #1;
        if (evt == rst_evt) check("tx_data_hold", tx_data, b);
        txrdy = 1'b1;
      end
    end
  end

  // Register-file responder: acks after bus_wait cycles, data valid only on ack.
  initial begin : bus_model
    acc_t a;
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reg_req && rst_n) begin
        a.we    = reg_we;
        a.addr  = reg_addr;
        a.wdata = reg_wdata;
        acc_q.push_back(a);
        repeat (bus_wait) @(posedge clk);
        #1;
        check("req_hold", reg_req, 1);
        check("addr_hold", reg_addr, a.addr);
        reg_rdata = mem[a.addr];
        reg_ack   = 1'b1;
        if (a.we) mem[a.addr] = a.wdata;
        @(posedge clk);
        #1;
        reg_ack   = 1'b0;
        reg_rdata = 8'($urandom_range(0, 255));
        check("req_drop", reg_req, 0);
      end
    end
  end

  // Predict the response from the frame alone, drive it, compare everything.
  task automatic run_frame(input bit inject);
    logic [7:0] cmd, x, st, d;
    logic [7:0] exp[4];
    bit         is_wr, injected, fin;
    int         n;
    n     = frame_q.size();
    cmd   = frame_q[1];
    is_wr = (cmd == CMD_WR);
    x     = 8'h00;
    for (int i = 1; i < n - 1; i++) x ^= frame_q[i];
    if (cmd != CMD_RD && cmd != CMD_WR) st = ST_BADCMD;
    else if (frame_q[n-1] != x)         st = ST_BADCHK;
    else                                st = ST_OK;
    d   = (st == ST_OK && !is_wr) ? mem[frame_q[2]] : 8'h00;
    exp = '{SYNC_TX, st, d, SYNC_TX ^ st ^ d};

    foreach (junk_q[i]) send_byte(junk_q[i], $urandom_range(0, 2));
    for (int i = 0; i < n; i++) send_byte(frame_q[i], (i == n - 1) ? 0 : $urandom_range(0, 3));
    @(negedge clk);
    check("req_latency", reg_req, st == ST_OK);
    tick();

    injected = 1'b0;
    fin      = 1'b0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (inject && !injected && tx_q.size() >= 1) begin
        injected = 1'b1;
        foreach (inj_q[i]) send_byte(inj_q[i], 1);
      end
      fin = (tx_q.size() >= 4 && !busy);
      if (!fin) tick();
    end
    check("rsp_done", fin, 1);
    repeat (40) tick();
    check("rsp_len", tx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < tx_q.size()) check($sformatf("rsp_byte%0d", i), tx_q[i], exp[i]);
    check("acc_cnt", acc_q.size(), (st == ST_OK) ? 1 : 0);
    if (st == ST_OK && acc_q.size() > 0) begin
      check("acc_we", acc_q[0].we, is_wr);
      check("acc_addr", acc_q[0].addr, frame_q[2]);
      if (is_wr) check("acc_wdata", acc_q[0].wdata, frame_q[3]);
    end
    if (st != ST_OK) bad_frames++;
    check("err_cnt", err_cnt, (bad_frames > 255) ? 255 : bad_frames);
    check("busy_idle", busy, 0);
    tx_q.delete();
    acc_q.delete();
    junk_q.delete();
  endtask

  task automatic random_frame(input bit force_bad);
    logic [7:0] cmd, x;
    int         r;
    r = $urandom_range(0, 9);
    if (r < 4)      cmd = CMD_RD;
    else if (r < 8) cmd = CMD_WR;
    else begin
      cmd = 8'($urandom_range(0, 255));
      if (cmd == CMD_RD || cmd == CMD_WR) cmd = 8'h07;
    end
    frame_q = '{SYNC_RX, cmd, 8'($urandom_range(0, 255))};
    if (cmd == CMD_WR) frame_q.push_back(8'($urandom_range(0, 255)));
    x = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
    if (force_bad || $urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  c;
    logic [7:0] b;
    rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00;
    tx_len = 3; bus_wait = 1; rst_evt = 0; bad_frames = 0;
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    repeat (3) tick();
    check("rst_tx_vld", tx_vld, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_reg_req", reg_req, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    frame_q = '{8'hA5, 8'h02, 8'h10, 8'h3C, 8'h2E}; run_frame(0);
    mem[8'h20] = 8'hC3; bus_wait = 3;
    frame_q = '{8'hA5, 8'h01, 8'h20, 8'h21};        run_frame(0);
    bus_wait = 1;
    frame_q = '{8'hA5, 8'h01, 8'h20, 8'h00};        run_frame(0);
    frame_q = '{8'hA5, 8'h07, 8'h20, 8'h27};        run_frame(0);

    // Junk before sync, plus a full frame thrown at a slow response.
    tx_len  = 286;
    junk_q  = '{8'h00, 8'hFF};
    inj_q   = '{8'hA5, 8'h01, 8'h20, 8'h21};
    frame_q = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h75}; run_frame(1);

    // Reset in the middle of the response.
    tx_len  = 20;
    frame_q = '{8'hA5, 8'h01, 8'h20, 8'h21};
    foreach (frame_q[i]) send_byte(frame_q[i], 0);
    c = 0;
    while (tx_q.size() < 2 && c < 2000) begin tick(); c++; end
    check("rsp_2nd_byte", tx_q.size() >= 2, 1);
    rst_n = 1'b0;
    rst_evt++;
    #1;
    check("abort_tx_vld", tx_vld, 0);
    check("abort_reg_req", reg_req, 0);
    check("abort_busy", busy, 0);
    check("abort_err_cnt", err_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    bad_frames = 0;
    tx_q.delete();
    acc_q.delete();
    tick();
    mem[8'h20] = 8'h5C;
    run_frame(0);
    tx_len = 3;

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    repeat (99) tick();
    @(negedge clk);
    check("tmo_busy_before", busy, 1);
    tick();
    @(negedge clk);
    check("tmo_busy_after", busy, 0);
    tick();
    repeat (40) tick();
    bad_frames++;
    check("tmo_no_tx", tx_q.size(), 0);
    check("tmo_no_req", acc_q.size(), 0);
    check("tmo_err_cnt", err_cnt, bad_frames);
    frame_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31}; run_frame(0);
`endif

    for (int k = 0; k < 40; k++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        b = 8'($urandom_range(0, 255));
        junk_q.push_back((b == SYNC_RX) ? 8'h00 : b);
      end
      bus_wait = $urandom_range(1, 4);
      random_frame(0);
      run_frame(0);
    end

    for (int k = 0; k < 260; k++) begin
      random_frame(1);
      run_frame(0);
    end
    check("err_saturated", err_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
